fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001: Parameter DEPTH, default 4, is the number of queue entries; it SHALL be a power of two and at least 2.
REQ-002: Parameter ISIZE, default 16, is the instruction width and the PC width.
REQ-003: clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004: rst  input  1  is the reset; it SHALL be synchronous and active-low.
REQ-005: imem_req  output  1  is the fetch request to I_memory for the current cycle.
REQ-006: imem_addr  output  ISIZE  is the fetch address and SHALL be valid while imem_req=1.
REQ-007: imem_data  input  ISIZE  is the instruction word; it SHALL be valid exactly one cycle after the cycle with imem_req=1.
REQ-008: redirect  input  1  is the branch/jump redirect from execute.
REQ-009: redirect_pc  input  ISIZE  is the redirect target, sampled when redirect=1.
REQ-010: stall  input  1  is the downstream hazard hold; while stall=1 the head entry SHALL NOT be consumed.
REQ-011: instr_valid  output  1  indicates that the head entry is present.
REQ-012: instr_out  output  ISIZE  is the head instruction, or 0 (NOP) when the queue is empty.
REQ-013: pc_out  output  ISIZE  is the head PC, or 0 when the queue is empty.
REQ-014: pc_plus1_out  output  ISIZE  is pc_out+1, modulo 2^ISIZE.
REQ-015: count  output  log2(DEPTH)+1  is the current occupancy.

Function
REQ-016: Internal state SHALL consist of fetch_pc, an inflight flag, a circular buffer of {pc, instr} with read and write pointers, and the occupancy counter.
REQ-017: pop SHALL be defined as instr_valid=1 AND stall=0 AND redirect=0.
REQ-018: imem_req SHALL be 1 iff redirect=0 AND (count + inflight - pop) < DEPTH.
REQ-019: imem_addr SHALL equal fetch_pc.
REQ-020: On an issued request, fetch_pc SHALL advance to fetch_pc+1, wrapping from 16'hFFFF to 16'h0000.
REQ-021: The inflight flag SHALL capture imem_req each cycle, so inflight=1 means imem_data is valid this cycle.
REQ-022: push SHALL be defined as inflight=1 AND redirect=0; a push writes {pc of that request, imem_data} at the write pointer, and the write pointer then increments modulo DEPTH.
REQ-023: A pop SHALL increment the read pointer modulo DEPTH.
REQ-024: Occupancy update: push only -> count+1; pop only -> count-1; push and pop together -> unchanged, including when count=DEPTH or count=0 with a bypass-free push.
REQ-025: The queue SHALL never overflow; REQ-018 guarantees that count+inflight never exceeds DEPTH.
REQ-026: Latency from request to output SHALL be 2 cycles: request in cycle N, data in N+1, visible at instr_out in N+2 when the queue was empty; there is no combinational bypass.
REQ-027: On redirect=1 in cycle N, at the end of N: the queue SHALL be emptied (pointers=0, count=0), fetch_pc SHALL be set to redirect_pc, and the imem_data returning in N SHALL be discarded.
REQ-028: On redirect=1, the request in cycle N SHALL be suppressed, and the first request to redirect_pc SHALL issue in N+1.
REQ-029: redirect SHALL take priority over stall, pop and push.
REQ-030: Redirect on consecutive cycles: each redirect overrides the previous one, and fetch resumes from the last redirect_pc.
REQ-031: Stall with a full queue SHALL hold all outputs stable and hold imem_req=0.
REQ-032: The outputs instr_out, pc_out, pc_plus1_out and instr_valid SHALL be driven directly from the head entry and count, with no dependence on stall.

Reset
REQ-033: When rst=0 at a clock edge: fetch_pc=16'h0000, inflight=0, pointers=0, count=0, and buffer contents don't-care.
REQ-034: During reset and in the first cycle after it: instr_valid=0, instr_out=0, pc_out=0, pc_plus1_out=1, imem_req=0 during rst=0.
REQ-035: The first request after reset release SHALL be to address 0, in the first cycle with rst=1.
REQ-036: Reset asserted mid-operation SHALL discard any in-flight response, with no push in the following cycle.

Verification
REQ-037: Reset release, stall=0, mem[i]=16'hA000+i -> req to 0,1,2,…; first instr_valid=1 two cycles after release with instr_out=16'hA000, pc_out=0, pc_plus1_out=1; then one instruction per cycle.
REQ-038: stall held 10 cycles from reset release -> count saturates at 4, imem_req=0 thereafter, and head stays pc 0; releasing stall -> pcs 0,1,2,3,4 delivered on consecutive cycles with no gap.
REQ-039: redirect=1 with redirect_pc=16'h0040 while count=3 and inflight=1 -> next cycle count=0, instr_valid=0, req addr 16'h0040; instr_out=mem[16'h0040] two cycles later; no stale pc delivered.
REQ-040: Wrap test: redirect_pc=16'hFFFE -> delivered pcs FFFE, FFFF, 0000, with pc_plus1_out for FFFF equal to 0000.
REQ-041: Random stall (50%) and sparse redirects over 2000 cycles against a reference model -> delivered pc sequence matches, count never exceeds 4, and no push occurs when count=4 without a pop.
REQ-042: rst=0 asserted for one cycle mid-stream with count=2 -> count=0, instr_valid=0, and the next req addr is 0.

Source files
------------

// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue
// ----------------------------------------------------------------------------
// Instruction fetch front end with a small decoupling queue. The block issues
// sequential fetch requests to a one-cycle-latency instruction memory, buffers
// the returned words together with their PCs in a circular queue, and presents
// the head entry to decode. A redirect from execute flushes everything and
// restarts fetch at the new target; a stall from downstream holds the head.
//
// Ports
//   clk           in   1      single clock, rising edge
//   rst           in   1      synchronous reset, active-low
//   imem_req      out  1      fetch request to instruction memory this cycle
//   imem_addr     out  ISIZE  fetch address (the current fetch PC)
//   imem_data     in   ISIZE  instruction word, valid one cycle after imem_req
//   redirect      in   1      branch/jump redirect, highest priority
//   redirect_pc   in   ISIZE  redirect target, sampled with redirect
//   stall         in   1      downstream hold; head entry is not consumed
//   instr_valid   out  1      head entry present
//   instr_out     out  ISIZE  head instruction, 0 (NOP) when empty
//   pc_out        out  ISIZE  head PC, 0 when empty
//   pc_plus1_out  out  ISIZE  pc_out + 1 (modulo 2^ISIZE)
//   count         out  AW+1   current queue occupancy
//
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int ISIZE = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [ISIZE-1:0]         imem_addr,
    input  logic [ISIZE-1:0]         imem_data,
    input  logic                     redirect,
    input  logic [ISIZE-1:0]         redirect_pc,
    input  logic                     stall,
    output logic                     instr_valid,
    output logic [ISIZE-1:0]         instr_out,
    output logic [ISIZE-1:0]         pc_out,
    output logic [ISIZE-1:0]         pc_plus1_out,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // One extra bit so occupancy plus the outstanding request never wraps.
    localparam int DW = CW + 1;

    // ------------------------------------------------------------------------
    // Control state (reset) and queue storage (no reset, contents don't-care)
    // ------------------------------------------------------------------------
    logic [ISIZE-1:0] fetch_pc;
    logic             inflight;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    occ;

    logic [ISIZE-1:0] buf_pc    [DEPTH];
    logic [ISIZE-1:0] buf_instr [DEPTH];

    logic             pop;
    logic             push;
    logic [DW-1:0]    demand;
    logic [ISIZE-1:0] resp_pc;

    // ------------------------------------------------------------------------
    // Stage p0: request decision
    // ------------------------------------------------------------------------
    // Head is consumed only when it exists, decode is not holding, and no
    // redirect is flushing the queue this cycle.
    assign pop  = instr_valid & ~stall & ~redirect;

    // A returning word is kept unless a redirect discards it.
    assign push = inflight & ~redirect;

    // Slots already claimed at the end of this cycle: stored entries plus the
    // word arriving now, minus the one leaving. A new request is allowed only
    // when it still has a guaranteed slot, so the queue can never overflow.
    assign demand = {1'b0, occ} + DW'(inflight) - DW'(pop);

    assign imem_req  = rst & ~redirect & (demand < DW'(DEPTH));
    assign imem_addr = fetch_pc;

    // Only one request can be outstanding and fetch_pc advanced past it when
    // it issued (a redirect in between suppresses both the request and the
    // push), so the PC of the returning word is always fetch_pc - 1.
    assign resp_pc = fetch_pc - ISIZE'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= '0;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
        end else if (redirect) begin
            // Flush: drop queued entries and the word returning this cycle,
            // and restart fetch at the target next cycle.
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                fetch_pc <= fetch_pc + ISIZE'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Stage p1: response capture into the queue
    // ------------------------------------------------------------------------
    // A word written during reset is harmless: the pointers and occupancy are
    // cleared at the same edge, so the entry is never read.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]    <= resp_pc;
            buf_instr[wr_ptr] <= imem_data;
        end
    end

    // ------------------------------------------------------------------------
    // Stage p2: head presentation (registered entries only, no bypass)
    // ------------------------------------------------------------------------
    assign instr_valid  = (occ != '0);
    assign instr_out    = instr_valid ? buf_instr[rd_ptr] : '0;
    assign pc_out       = instr_valid ? buf_pc[rd_ptr]    : '0;
    assign pc_plus1_out = pc_out + ISIZE'(1);
    assign count        = occ;

endmodule

// File: tb/tb_fetch_queue.sv
// ============================================================================
// tb_fetch_queue
// ----------------------------------------------------------------------------
// Directed and randomized bench for fetch_queue (DEPTH=4, ISIZE=16). A
// one-cycle memory returns 16'hA000 + address. A small behavioural model of
// occupancy, request and the next PC to deliver is compared every cycle,
// alongside hand-computed checks for the reset, stall, redirect and wrap
// scenarios.
// ============================================================================
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_data = 16'h0000;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        stall = 1'b0;
    logic        instr_valid;
    logic [15:0] instr_out;
    logic [15:0] pc_out;
    logic [15:0] pc_plus1_out;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    fetch_queue #(.DEPTH(4), .ISIZE(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .stall        (stall),
        .instr_valid  (instr_valid),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .pc_plus1_out (pc_plus1_out),
        .count        (count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return 16'hA000 + a;
    endfunction

    // Instruction memory: one-cycle latency; garbage when nothing was asked.
    always @(posedge clk) begin
        imem_data <= imem_req ? memf(imem_addr) : 16'hDEAD;
    end

    // Reference model state
    logic [15:0] m_fetch = 16'h0000;
    logic [15:0] m_exp   = 16'h0000;
    logic        m_infl  = 1'b0;
    int          m_cnt   = 0;
    logic        m_pop;
    logic        m_req;

    always_comb begin
        m_pop = 1'b0;
        m_req = 1'b0;
        m_pop = rst && (m_cnt != 0) && !stall && !redirect;
        m_req = rst && !redirect &&
                ((m_cnt + (m_infl ? 1 : 0) - (m_pop ? 1 : 0)) < 4);
    end

    always @(posedge clk) begin
        if (!rst) begin
            m_fetch <= 16'h0000;
            m_exp   <= 16'h0000;
            m_infl  <= 1'b0;
            m_cnt   <= 0;
        end else if (redirect) begin
            m_fetch <= redirect_pc;
            m_exp   <= redirect_pc;
            m_infl  <= 1'b0;
            m_cnt   <= 0;
        end else begin
            m_cnt  <= m_cnt + (m_infl ? 1 : 0) - (m_pop ? 1 : 0);
            m_infl <= m_req;
            if (m_req) m_fetch <= m_fetch + 16'd1;
            if (m_pop) m_exp   <= m_exp + 16'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_check();
        check("m_req", imem_req, m_req);
        if (m_req) check("m_addr", imem_addr, m_fetch);
        check("m_cnt", count, m_cnt);
        check("m_vld", instr_valid, m_cnt != 0);
        if (m_cnt != 0) begin
            check("m_pc", pc_out, m_exp);
            check("m_instr", instr_out, memf(m_exp));
            check("m_pc1", pc_plus1_out, 16'(m_exp + 16'd1));
        end else begin
            check("m_nop", instr_out, 16'h0000);
            check("m_pc0", pc_out, 16'h0000);
            check("m_pc1e", pc_plus1_out, 16'h0001);
        end
    endtask

    // Drive one cycle's inputs on the falling edge, then check settled outputs.
    task automatic cyc(input logic r, input logic s, input logic rd, input logic [15:0] rp);
        @(negedge clk);
        rst         = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rp;
        #1;
        model_check();
    endtask

    initial begin
        // Reset and first fetches
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        check("rst_req", imem_req, 1'b0);
        check("rst_vld", instr_valid, 1'b0);
        check("rst_instr", instr_out, 16'h0000);
        check("rst_pc1", pc_plus1_out, 16'h0001);

        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("go_req0", imem_req, 1'b1);
        check("go_addr0", imem_addr, 16'h0000);
        check("go_vld0", instr_valid, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("go_addr1", imem_addr, 16'h0001);
        check("go_vld1", instr_valid, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("go_vld2", instr_valid, 1'b1);
        check("go_instr2", instr_out, 16'hA000);
        check("go_pc2", pc_out, 16'h0000);
        check("go_pc1_2", pc_plus1_out, 16'h0001);
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 16'h0000);
            check("seq_pc", pc_out, 16'(i));
            check("seq_instr", instr_out, 16'(16'hA000 + i));
        end

        // Stall from release until the queue fills, then drain without gaps
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 16'h0000);
            if (k == 0) check("st_req0", imem_req, 1'b1);
            if (k >= 5) begin
                check("st_cnt4", count, 3'd4);
                check("st_req", imem_req, 1'b0);
                check("st_pc", pc_out, 16'h0000);
            end
        end
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 16'h0000);
            check("dr_vld", instr_valid, 1'b1);
            check("dr_pc", pc_out, 16'(k));
        end

        // Redirect with three queued entries and one word in flight
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b0, 16'h0000);
        cyc(1'b1, 1'b1, 1'b1, 16'h0040);
        check("rd_cnt3", count, 3'd3);
        check("rd_req", imem_req, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("rd_cnt0", count, 3'd0);
        check("rd_vld0", instr_valid, 1'b0);
        check("rd_req1", imem_req, 1'b1);
        check("rd_addr", imem_addr, 16'h0040);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("rd_vld1", instr_valid, 1'b0);
        check("rd_addr1", imem_addr, 16'h0041);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("rd_vld2", instr_valid, 1'b1);
        check("rd_pc", pc_out, 16'h0040);
        check("rd_instr", instr_out, 16'hA040);

        // PC wrap
        cyc(1'b1, 1'b0, 1'b1, 16'hFFFE);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("wr_addr0", imem_addr, 16'hFFFE);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("wr_addr1", imem_addr, 16'hFFFF);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("wr_pc0", pc_out, 16'hFFFE);
        check("wr_addr2", imem_addr, 16'h0000);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("wr_pc1", pc_out, 16'hFFFF);
        check("wr_pc1p", pc_plus1_out, 16'h0000);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("wr_pc2", pc_out, 16'h0000);
        check("wr_instr2", instr_out, 16'hA000);

        // Back-to-back redirects: the last one wins
        cyc(1'b1, 1'b0, 1'b1, 16'h0100);
        cyc(1'b1, 1'b0, 1'b1, 16'h0200);
        check("rr_req", imem_req, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("rr_addr", imem_addr, 16'h0200);
        check("rr_vld", instr_valid, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("rr_pc", pc_out, 16'h0200);

        // One-cycle reset mid-stream with two entries queued
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b0, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        check("mr_cnt2", count, 3'd2);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("mr_cnt0", count, 3'd0);
        check("mr_vld0", instr_valid, 1'b0);
        check("mr_addr", imem_addr, 16'h0000);
        check("mr_req", imem_req, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("mr_cnt0b", count, 3'd0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("mr_pc", pc_out, 16'h0000);

        // Random stall with sparse redirects
        for (int n = 0; n < 2000; n++) begin
            logic s;
            logic rd;
            logic [15:0] rp;
            s  = 1'($urandom_range(0, 1));
            rd = ($urandom_range(0, 49) == 0);
            rp = 16'($urandom);
            cyc(1'b1, s, rd, rp);
            check("cnt_max", count <= 3'd4, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
